input_conditioner: RTL and testbench

//  Conditions the raw board inputs that drive the Gray-decoder/display top: 4 Gray-code slide switches and the decades button.
//  Per-channel 2-FF synchroniser plus counter-based debouncer produces stable, glitch-free levels for gray_code.

---
 rtl/input_conditioner.sv | 87 ++++++++
 tb/tb_input_conditioner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Board input conditioner: 2-FF synchronisers and counter debouncers for four Gray-code
// switches and the decades button, plus press-edge pulse and show_decades toggle.
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 270_000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw_in,
   input  logic       btn_in,
   output logic [3:0] gray_code,
   output logic       show_decades,
   output logic       btn_pulse
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int              NCH      = 5;
   localparam int              BTN_CH   = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic            BTN_IDLE = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;
   localparam logic [NCH-1:0]  SYNC_RST = {BTN_IDLE, 4'b0000};

   logic [NCH-1:0] r_sync1;
   logic [NCH-1:0] r_sync2;
   logic [NCH-1:0] w_level;
   logic [NCH-1:0] w_st;
   logic           r_pressed_q;
   logic           r_show_decades;
   logic           r_btn_pulse;
   logic           w_press_edge;

   // Button sync FFs idle at the released level so reset never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= SYNC_RST;
         r_sync2 <= SYNC_RST;
      end else begin
         r_sync1 <= {btn_in, sw_in};
         r_sync2 <= r_sync1;
      end
   end

   // Button level normalised to 1 = pressed before debouncing.
   assign w_level = {r_sync2[BTN_CH] ^ BTN_IDLE, r_sync2[3:0]};

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic             r_st;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_st  <= 1'b0;
            r_cnt <= '0;
         end else if (w_level[g] == r_st) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_st  <= w_level[g];
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end

      assign w_st[g] = r_st;
   end

   assign w_press_edge = w_st[BTN_CH] & ~r_pressed_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pressed_q    <= 1'b0;
         r_btn_pulse    <= 1'b0;
         r_show_decades <= 1'b0;
      end else begin
         r_pressed_q <= w_st[BTN_CH];
         r_btn_pulse <= w_press_edge;
         if (w_press_edge) begin
            r_show_decades <= ~r_show_decades;
         end
      end
   end

   assign gray_code    = w_st[3:0];
   assign show_decades = r_show_decades;
   assign btn_pulse    = r_btn_pulse;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with an 8-cycle debounce window and an
// active-low button.
module tb_input_conditioner;

   logic       clk;
   logic       rst_n;
   logic [3:0] sw_in;
   logic       btn_in;
   logic [3:0] gray_code;
   logic       show_decades;
   logic       btn_pulse;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;
   logic exp_show = 1'b0;

   input_conditioner #(
      .DEBOUNCE_CYCLES(8),
      .BTN_ACTIVE_LOW (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sw_in       (sw_in),
      .btn_in      (btn_in),
      .gray_code   (gray_code),
      .show_decades(show_decades),
      .btn_pulse   (btn_pulse)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Each strobe cycle is seen at exactly one falling edge.
   always @(negedge clk) begin
      if (btn_pulse === 1'b1) pulse_cnt = pulse_cnt + 1;
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      int base;
      rst_n  = 1'b0;
      sw_in  = 4'hF;
      btn_in = 1'b0;
      step(3);
      checks++;
      if (gray_code !== 4'h0) begin
         errors++; $display("FAIL reset_gray: got %h expected 0", gray_code);
      end
      checks++;
      if (show_decades !== 1'b0) begin
         errors++; $display("FAIL reset_show: got %b expected 0", show_decades);
      end
      checks++;
      if (btn_pulse !== 1'b0) begin
         errors++; $display("FAIL reset_pulse: got %b expected 0", btn_pulse);
      end
      base  = pulse_cnt;
      rst_n = 1'b1;
      step(9);
      checks++;
      if (gray_code !== 4'h0) begin
         errors++; $display("FAIL reset_gray_early: got %h expected 0", gray_code);
      end
      step(1);
      checks++;
      if (gray_code !== 4'hF) begin
         errors++; $display("FAIL reset_gray_10: got %h expected f", gray_code);
      end
      step(1);
      checks++;
      if (btn_pulse !== 1'b1) begin
         errors++; $display("FAIL reset_press_pulse: got %b expected 1", btn_pulse);
      end
      exp_show = 1'b1;
      step(10);
      checks++;
      if (pulse_cnt - base !== 1) begin
         errors++; $display("FAIL reset_pulse_count: got %0d expected 1", pulse_cnt - base);
      end
      checks++;
      if (show_decades !== exp_show) begin
         errors++; $display("FAIL reset_show_toggle: got %b expected %b", show_decades, exp_show);
      end
      // release button and clear switches ahead of the next scenario
      base   = pulse_cnt;
      btn_in = 1'b1;
      sw_in  = 4'h0;
      step(15);
      checks++;
      if (gray_code !== 4'h0) begin
         errors++; $display("FAIL reset_sw_clear: got %h expected 0", gray_code);
      end
      checks++;
      if (pulse_cnt - base !== 0) begin
         errors++; $display("FAIL release_no_pulse: got %0d expected 0", pulse_cnt - base);
      end
   endtask

   task automatic test_clean_switch;
      sw_in = 4'b0001;
      step(9);
      checks++;
      if (gray_code !== 4'b0000) begin
         errors++; $display("FAIL clean_early: got %b expected 0000", gray_code);
      end
      step(1);
      checks++;
      if (gray_code !== 4'b0001) begin
         errors++; $display("FAIL clean_10: got %b expected 0001", gray_code);
      end
   endtask

   task automatic test_bounce;
      for (int t = 0; t < 13; t++) begin
         sw_in[2] = ~sw_in[2];
         if (t < 12) begin
            for (int k = 0; k < 3; k++) begin
               step(1);
               checks++;
               if (gray_code !== 4'b0001) begin
                  errors++; $display("FAIL bounce_hold t=%0d: got %b expected 0001", t, gray_code);
               end
            end
         end
      end
      step(9);
      checks++;
      if (gray_code !== 4'b0001) begin
         errors++; $display("FAIL bounce_early: got %b expected 0001", gray_code);
      end
      step(1);
      checks++;
      if (gray_code !== 4'b0101) begin
         errors++; $display("FAIL bounce_10: got %b expected 0101", gray_code);
      end
   endtask

   task automatic test_async_reset;
      sw_in = 4'b0110;
      step(5);
      rst_n = 1'b0;
      #1;
      checks++;
      if (gray_code !== 4'h0) begin
         errors++; $display("FAIL async_gray: got %h expected 0", gray_code);
      end
      checks++;
      if (show_decades !== 1'b0) begin
         errors++; $display("FAIL async_show: got %b expected 0", show_decades);
      end
      exp_show = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(9);
      checks++;
      if (gray_code !== 4'h0) begin
         errors++; $display("FAIL async_restart_early: got %b expected 0000", gray_code);
      end
      step(1);
      checks++;
      if (gray_code !== 4'b0110) begin
         errors++; $display("FAIL async_restart_10: got %b expected 0110", gray_code);
      end
   endtask

   task automatic test_button;
      int base;
      logic [11:0] bounce_pat;
      bounce_pat = 12'b100100100100;
      base = pulse_cnt;
      for (int t = 0; t < 50; t++) begin
         btn_in = (t < 12) ? bounce_pat[t] : 1'b0;
         step(1);
      end
      btn_in = 1'b1;
      step(30);
      exp_show = ~exp_show;
      checks++;
      if (pulse_cnt - base !== 1) begin
         errors++; $display("FAIL button_pulse_count: got %0d expected 1", pulse_cnt - base);
      end
      checks++;
      if (show_decades !== exp_show) begin
         errors++; $display("FAIL button_show: got %b expected %b", show_decades, exp_show);
      end
      base   = pulse_cnt;
      btn_in = 1'b0;
      step(10);
      checks++;
      if (btn_pulse !== 1'b0) begin
         errors++; $display("FAIL press2_early: got %b expected 0", btn_pulse);
      end
      step(1);
      exp_show = ~exp_show;
      checks++;
      if (btn_pulse !== 1'b1) begin
         errors++; $display("FAIL press2_pulse: got %b expected 1", btn_pulse);
      end
      checks++;
      if (show_decades !== exp_show) begin
         errors++; $display("FAIL press2_show: got %b expected %b", show_decades, exp_show);
      end
      step(1);
      checks++;
      if (btn_pulse !== 1'b0) begin
         errors++; $display("FAIL press2_one_cycle: got %b expected 0", btn_pulse);
      end
      step(20);
      btn_in = 1'b1;
      step(30);
      checks++;
      if (pulse_cnt - base !== 1) begin
         errors++; $display("FAIL press2_count: got %0d expected 1", pulse_cnt - base);
      end
      checks++;
      if (show_decades !== exp_show) begin
         errors++; $display("FAIL press2_show_after: got %b expected %b", show_decades, exp_show);
      end
   endtask

   task automatic test_glitch;
      int base;
      int blips[7];
      logic hit;
      blips = '{5, 20, 47, 80, 111, 150, 190};
      base  = pulse_cnt;
      for (int t = 0; t < 200; t++) begin
         hit = 1'b0;
         for (int j = 0; j < 7; j++) begin
            if (blips[j] == t) hit = 1'b1;
         end
         btn_in = ~hit;
         step(1);
      end
      btn_in = 1'b1;
      step(15);
      checks++;
      if (pulse_cnt - base !== 0) begin
         errors++; $display("FAIL glitch_pulse: got %0d expected 0", pulse_cnt - base);
      end
      checks++;
      if (show_decades !== exp_show) begin
         errors++; $display("FAIL glitch_show: got %b expected %b", show_decades, exp_show);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      sw_in  = 4'h0;
      btn_in = 1'b1;
      test_reset();
      test_clean_switch();
      test_bounce();
      test_async_reset();
      test_button();
      test_glitch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
